tile_selector: RTL and testbench
================================

# tile_selector

Consumes the one-hot 36-bit cursor bus produced by the cursor block and turns player "select" presses into an ordered pair of tile indices for the match checker. It decodes the one-hot bus back to a row-major index (row*COLS + col) and holds the first pick, highlighting it for the display. On the second pick it presents the pair over a valid/ready handshake. It sits between the cursor/button front end and the match logic.

## Interface
- ROWS, 6, board rows
- COLS, 6, board columns
- N, ROWS*COLS (36), cursor bus width
- IDX_W, 6, index width; must satisfy 2^IDX_W >= N

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cur_bus  in  N  one-hot cursor position; bit i set = cursor on tile i
- select  in  1  single-cycle pulse, debounced select button
- cancel  in  1  single-cycle pulse, drop current selection
- pair_ready  in  1  match checker accepts pair this cycle
- pair_valid  out  1  pair_a/pair_b hold a complete pair
- pair_a  out  IDX_W  first selected tile index
- pair_b  out  IDX_W  second selected tile index
- sel_bus  out  N  one-hot highlight of selected tile(s) for display
- bad_cursor  out  1  one-cycle pulse: select seen while cur_bus not exactly one-hot

## Operation
- Decode: cur_ok = exactly one bit of cur_bus set; cur_idx = position of that bit. When cur_ok = 0, cur_idx is don't-care and must not be captured.
- States: IDLE (nothing held), ONE (pair_a held), PAIR (pair_a, pair_b held, pair_valid = 1).
- IDLE:
  - select & cur_ok -> pair_a <= cur_idx, go ONE.
  - select & !cur_ok -> bad_cursor pulse, stay.
  - cancel -> no effect.
- ONE:
  - cancel -> IDLE, pair_a <= 0. Cancel wins over a simultaneous select.
  - select & cur_ok & cur_idx == pair_a -> deselect, go IDLE, pair_a <= 0.
  - select & cur_ok & cur_idx != pair_a -> pair_b <= cur_idx, go PAIR.
  - select & !cur_ok -> bad_cursor pulse, stay ONE.
- PAIR:
  - pair_ready -> IDLE, pair_a <= 0, pair_b <= 0.
  - select and cancel are ignored; no bad_cursor pulse. pair_a/pair_b stay stable until the handshake completes.
- sel_bus:
  - IDLE: 0.
  - ONE: onehot(pair_a).
  - PAIR: onehot(pair_a) | onehot(pair_b).
- Indices are always < N; no arithmetic beyond the equality compare.

## Timing
- All outputs are registered. Reset values: state IDLE, pair_valid 0, pair_a 0, pair_b 0, sel_bus 0, bad_cursor 0.
- select sampled at edge k:
  - state, pair_a/pair_b and sel_bus update at edge k.
  - pair_valid is visible in cycle k+1.
- Handshake: the transfer occurs on the edge where pair_valid & pair_ready are both 1. pair_valid drops the next cycle. pair_ready while pair_valid = 0 is ignored.
- Minimum spacing: the pair is consumed on the edge it is accepted. A select pulse on that same edge is dropped, not queued.
- bad_cursor is high exactly one cycle, after the offending edge.
- rst_n low at any time clears everything immediately, including mid-handshake; pair_valid falls asynchronously. Release is synchronous to clk by the system reset synchroniser.

## Structure
- Shared package `tile_pkg`: ROWS, COLS, N, IDX_W, index typedef, state enum {IDLE, ONE, PAIR}. The cursor block and the match checker use the same package.
- Sub-module `onehot_decode` (parameter N, IDX_W): inputs `bus`; outputs `idx` and `ok`. Purely combinational, reusable by the display path.
- The onehot(idx) expansion for sel_bus is a function in `tile_pkg`.

## Test plan
- Reset, then select with cur_bus = 1<<7, then select with cur_bus = 1<<20:
  - pair_valid = 1, pair_a = 7, pair_b = 20.
  - sel_bus = (1<<7)|(1<<20).
  - Hold until pair_ready; one cycle later everything is 0.
- Select at tile 14, then select at tile 14 again:
  - Returns to IDLE, sel_bus = 0, pair_valid never asserts.
- Select with cur_bus = 0, then with cur_bus = (1<<3)|(1<<4):
  - bad_cursor pulses once per select.
  - State stays IDLE; pair_a stays 0.
- In ONE (pair_a = 5), select and cancel in the same cycle:
  - Goes to IDLE, sel_bus = 0.
- In PAIR (0, 35), pair_ready held low 10 cycles while select/cancel toggle:
  - Outputs stay stable. Then pair_ready and select asserted together -> IDLE, and the select is dropped.
- Assert rst_n = 0 mid-cycle while pair_valid = 1:
  - pair_valid and sel_bus go 0 without waiting for a clock edge.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared board geometry, tile index type and selector states.
// Used by the cursor block, the tile selector and the match checker.
package tile_pkg;

  localparam int ROWS  = 6;
  localparam int COLS  = 6;
  localparam int N     = ROWS * COLS;
  localparam int IDX_W = 6;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    PAIR = 2'd2
  } sel_state_t;

  function automatic logic [N-1:0] onehot(input idx_t idx);
    logic [N-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// One-hot bus to binary index decoder with an exactly-one-bit flag.
// Purely combinational; idx is meaningful only when ok is high.
module onehot_decode #(
  parameter int N     = 36,
  parameter int IDX_W = 6
) (
  input  logic [N-1:0]     bus,
  output logic [IDX_W-1:0] idx,
  output logic             ok
);

  logic seen;
  logic multi;

  // OR of set-bit positions equals the position when only one is set
  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = idx | IDX_W'(i);
      end
    end
  end

  assign ok = seen & ~multi;

endmodule

// File: rtl/tile_selector.sv
// Turns select presses on a one-hot cursor into an ordered tile pair
// presented over valid/ready, with a highlight bus for the display.
module tile_selector
  import tile_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] cur_bus,
  input  logic         select,
  input  logic         cancel,
  input  logic         pair_ready,
  output logic         pair_valid,
  output idx_t         pair_a,
  output idx_t         pair_b,
  output logic [N-1:0] sel_bus,
  output logic         bad_cursor
);

  sel_state_t state;
  idx_t       cur_idx;
  logic       cur_ok;

  onehot_decode #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_dec (
    .bus (cur_bus),
    .idx (cur_idx),
    .ok  (cur_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pair_valid <= 1'b0;
      pair_a     <= '0;
      pair_b     <= '0;
      sel_bus    <= '0;
      bad_cursor <= 1'b0;
    end else begin
      bad_cursor <= 1'b0;
      unique case (state)
        IDLE: begin
          if (select && cur_ok) begin
            pair_a  <= cur_idx;
            sel_bus <= onehot(cur_idx);
            state   <= ONE;
          end else if (select) begin
            bad_cursor <= 1'b1;
          end
        end
        ONE: begin
          // cancel outranks a same-cycle select
          if (cancel) begin
            pair_a  <= '0;
            sel_bus <= '0;
            state   <= IDLE;
          end else if (select && cur_ok) begin
            if (cur_idx == pair_a) begin
              pair_a  <= '0;
              sel_bus <= '0;
              state   <= IDLE;
            end else begin
              pair_b     <= cur_idx;
              sel_bus    <= onehot(pair_a) | onehot(cur_idx);
              pair_valid <= 1'b1;
              state      <= PAIR;
            end
          end else if (select) begin
            bad_cursor <= 1'b1;
          end
        end
        PAIR: begin
          if (pair_ready) begin
            pair_a     <= '0;
            pair_b     <= '0;
            sel_bus    <= '0;
            pair_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          pair_a     <= '0;
          pair_b     <= '0;
          sel_bus    <= '0;
          pair_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tile_selector.sv
// Directed bench for tile_selector: pairing, deselect, bad cursor,
// cancel priority, handshake hold and asynchronous reset.
module tb_tile_selector;
  import tile_pkg::*;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] cur_bus;
  logic         select;
  logic         cancel;
  logic         pair_ready;
  logic         pair_valid;
  idx_t         pair_a;
  idx_t         pair_b;
  logic [N-1:0] sel_bus;
  logic         bad_cursor;

  int passed;
  int total;

  tile_selector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cur_bus    (cur_bus),
    .select     (select),
    .cancel     (cancel),
    .pair_ready (pair_ready),
    .pair_valid (pair_valid),
    .pair_a     (pair_a),
    .pair_b     (pair_b),
    .sel_bus    (sel_bus),
    .bad_cursor (bad_cursor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Pulse select for one rising edge; returns at the following negedge.
  task automatic press(input logic [N-1:0] bus, input logic cn);
    @(negedge clk);
    cur_bus = bus;
    select  = 1'b1;
    cancel  = cn;
    @(negedge clk);
    select  = 1'b0;
    cancel  = 1'b0;
    cur_bus = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cur_bus = '0;
    select = 1'b0;
    cancel = 1'b0;
    pair_ready = 1'b0;
    #1;
    total++;
    if (pair_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", pair_valid);
    else passed++;
    total++;
    if (pair_a !== 6'd0 || pair_b !== 6'd0)
      $display("FAIL rst_pair got %0d,%0d want 0,0", pair_a, pair_b);
    else passed++;
    total++;
    if (sel_bus !== '0) $display("FAIL rst_sel got %h want 0", sel_bus);
    else passed++;
    total++;
    if (bad_cursor !== 1'b0) $display("FAIL rst_bad got %b want 0", bad_cursor);
    else passed++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pair;
    logic [N-1:0] want;
    press(bit_at(7), 1'b0);
    total++;
    if (sel_bus !== bit_at(7) || pair_valid !== 1'b0 || pair_a !== 6'd7)
      $display("FAIL first_pick got sel=%h v=%b a=%0d want sel=%h v=0 a=7",
               sel_bus, pair_valid, pair_a, bit_at(7));
    else passed++;
    press(bit_at(20), 1'b0);
    want = bit_at(7) | bit_at(20);
    total++;
    if (pair_valid !== 1'b1 || pair_a !== 6'd7 || pair_b !== 6'd20)
      $display("FAIL pair_out got v=%b a=%0d b=%0d want 1,7,20",
               pair_valid, pair_a, pair_b);
    else passed++;
    total++;
    if (sel_bus !== want) $display("FAIL pair_sel got %h want %h", sel_bus, want);
    else passed++;
    repeat (3) @(negedge clk);
    total++;
    if (pair_valid !== 1'b1 || pair_b !== 6'd20)
      $display("FAIL pair_hold got v=%b b=%0d want 1,20", pair_valid, pair_b);
    else passed++;
    pair_ready = 1'b1;
    @(negedge clk);
    pair_ready = 1'b0;
    total++;
    if ({pair_valid, pair_a, pair_b} !== 13'd0 || sel_bus !== '0)
      $display("FAIL accept_clear got v=%b a=%0d b=%0d sel=%h want all 0",
               pair_valid, pair_a, pair_b, sel_bus);
    else passed++;
  endtask

  task automatic test_deselect;
    press(bit_at(14), 1'b0);
    total++;
    if (sel_bus !== bit_at(14) || pair_a !== 6'd14)
      $display("FAIL desel_pick got sel=%h a=%0d want sel=%h a=14",
               sel_bus, pair_a, bit_at(14));
    else passed++;
    press(bit_at(14), 1'b0);
    total++;
    if (sel_bus !== '0 || pair_a !== 6'd0 || pair_valid !== 1'b0)
      $display("FAIL deselect got sel=%h a=%0d v=%b want 0,0,0",
               sel_bus, pair_a, pair_valid);
    else passed++;
    // Must still be in IDLE: a new pick takes pair_a, no pair forms
    press(bit_at(2), 1'b0);
    total++;
    if (pair_a !== 6'd2 || pair_valid !== 1'b0)
      $display("FAIL desel_idle got a=%0d v=%b want 2,0", pair_a, pair_valid);
    else passed++;
    do_reset();
  endtask

  task automatic test_bad_cursor;
    press('0, 1'b0);
    total++;
    if (bad_cursor !== 1'b1) $display("FAIL bad_zero got %b want 1", bad_cursor);
    else passed++;
    @(negedge clk);
    total++;
    if (bad_cursor !== 1'b0) $display("FAIL bad_width got %b want 0", bad_cursor);
    else passed++;
    press(bit_at(3) | bit_at(4), 1'b0);
    total++;
    if (bad_cursor !== 1'b1) $display("FAIL bad_multi got %b want 1", bad_cursor);
    else passed++;
    total++;
    if (pair_a !== 6'd0 || sel_bus !== '0)
      $display("FAIL bad_idle got a=%0d sel=%h want 0,0", pair_a, sel_bus);
    else passed++;
    // In ONE, a bad cursor pulses but keeps the held pick
    press(bit_at(9), 1'b0);
    press(bit_at(0) | bit_at(35), 1'b0);
    total++;
    if (bad_cursor !== 1'b1 || pair_a !== 6'd9 || sel_bus !== bit_at(9))
      $display("FAIL bad_one got bad=%b a=%0d want 1,9", bad_cursor, pair_a);
    else passed++;
    do_reset();
  endtask

  task automatic test_cancel_wins;
    press(bit_at(5), 1'b0);
    total++;
    if (pair_a !== 6'd5) $display("FAIL cancel_pick got %0d want 5", pair_a);
    else passed++;
    press(bit_at(11), 1'b1);
    total++;
    if (sel_bus !== '0 || pair_a !== 6'd0 || pair_valid !== 1'b0)
      $display("FAIL cancel_wins got sel=%h a=%0d v=%b want 0,0,0",
               sel_bus, pair_a, pair_valid);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] want;
    logic         stable;
    want = bit_at(0) | bit_at(35);
    press(bit_at(0), 1'b0);
    press(bit_at(35), 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cur_bus = bit_at(i + 1);
      select  = i[0];
      cancel  = ~i[0];
      @(negedge clk);
      if ({pair_valid, pair_a, pair_b} !== {1'b1, 6'd0, 6'd35} ||
          sel_bus !== want || bad_cursor !== 1'b0)
        stable = 1'b0;
    end
    cancel = 1'b0;
    total++;
    if (stable !== 1'b1)
      $display("FAIL pair_stable got v=%b a=%0d b=%0d sel=%h want 1,0,35,%h",
               pair_valid, pair_a, pair_b, sel_bus, want);
    else passed++;
    cur_bus = bit_at(3);
    select = 1'b1;
    pair_ready = 1'b1;
    @(negedge clk);
    select = 1'b0;
    pair_ready = 1'b0;
    cur_bus = '0;
    total++;
    if ({pair_valid, pair_a, pair_b} !== 13'd0 || sel_bus !== '0)
      $display("FAIL accept_drop got v=%b a=%0d b=%0d sel=%h want all 0",
               pair_valid, pair_a, pair_b, sel_bus);
    else passed++;
    @(negedge clk);
    total++;
    if (sel_bus !== '0 || pair_a !== 6'd0)
      $display("FAIL drop_idle got sel=%h a=%0d want 0,0", sel_bus, pair_a);
    else passed++;
  endtask

  task automatic test_async_reset;
    press(bit_at(12), 1'b0);
    press(bit_at(30), 1'b0);
    total++;
    if (pair_valid !== 1'b1)
      $display("FAIL arst_setup got %b want 1", pair_valid);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (pair_valid !== 1'b0 || sel_bus !== '0)
      $display("FAIL arst got v=%b sel=%h want 0,0", pair_valid, sel_bus);
    else passed++;
    total++;
    if (pair_a !== 6'd0 || pair_b !== 6'd0)
      $display("FAIL arst_pair got %0d,%0d want 0,0", pair_a, pair_b);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_pair();
    test_deselect();
    test_bad_cursor();
    test_cancel_wins();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
